// File: rtl/rtc_ctrl_arb_pkg.sv
// rtc_ctrl_arb_pkg: shared widths, timeout default and FSM encoding for the rtc control arbiter
package rtc_ctrl_arb_pkg;
  localparam int NS_W = 38;
  localparam int SEC_W = 48;
  localparam int PER_W = 40;
  localparam int ADJ_W = 32;
  localparam logic [31:0] TIMEOUT_DEF = 32'd1000000;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LD_TIME = 3'd1;
  localparam logic [2:0] S_LD_PERIOD = 3'd2;
  localparam logic [2:0] S_ADJ_ISSUE = 3'd3;
  localparam logic [2:0] S_ADJ_WAIT = 3'd4;
endpackage

// File: rtl/rtc_ctrl_tmo.sv
// rtc_ctrl_tmo: clearable, enabled timeout counter flagging the last cycle before limit
module rtc_ctrl_tmo (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] limit,
  output logic        expire
);
  logic [31:0] cnt;
  assign expire = en && ({1'b0, cnt} + 33'd2 >= {1'b0, limit});
  // count while enabled, stop once expired, restart on clr
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expire) cnt <= cnt + 32'd1;
endmodule

// File: rtl/rtc_ctrl_arb.sv
// rtc_ctrl_arb: arbitrates time, period and adjust requests onto the rtc load ports
module rtc_ctrl_arb
  import rtc_ctrl_arb_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = TIMEOUT_DEF,
  parameter int PRIO_TIME = 1
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             tl_req,
  input  logic [NS_W-1:0]  tl_ns,
  input  logic [SEC_W-1:0] tl_sec,
  output logic             tl_ack,
  input  logic             pl_req,
  input  logic [PER_W-1:0] pl_period,
  output logic             pl_ack,
  input  logic             aj_req,
  input  logic [ADJ_W-1:0] aj_cycles,
  input  logic [PER_W-1:0] aj_period,
  output logic             aj_ack,
  output logic             aj_done,
  output logic             aj_err,
  output logic             time_ld,
  output logic [NS_W-1:0]  time_reg_ns_in,
  output logic [SEC_W-1:0] time_reg_sec_in,
  output logic             period_ld,
  output logic [PER_W-1:0] period_in,
  output logic             adj_ld,
  output logic [ADJ_W-1:0] adj_ld_data,
  output logic [PER_W-1:0] period_adj,
  input  logic             adj_ld_done,
  output logic             busy
);
  logic [2:0] state, nxt;
  logic armed, adj_pend, done_q, err_q, expire, fin, adj_zero;
  logic g_time, g_per, g_adj;
  assign adj_zero = adj_ld_data == '0;
  assign fin = adj_pend && (adj_ld_done || expire);
  assign g_time = armed && tl_req && (state == S_ADJ_WAIT || (state == S_IDLE && (PRIO_TIME != 0 || !pl_req)));
  assign g_per = armed && state == S_IDLE && pl_req && !g_time;
  assign g_adj = armed && state == S_IDLE && aj_req && !g_time && !g_per;
  assign time_ld = state == S_LD_TIME;
  assign tl_ack = time_ld;
  assign period_ld = state == S_LD_PERIOD;
  assign pl_ack = period_ld;
  assign aj_ack = state == S_ADJ_ISSUE;
  assign adj_ld = aj_ack && !adj_zero;
  assign aj_done = done_q || (aj_ack && adj_zero);
  assign aj_err = err_q || (aj_ack && adj_zero);
  assign busy = state != S_IDLE;
  rtc_ctrl_tmo u_tmo (
    .clk(clk),
    .rst(rst),
    .clr(aj_ack),
    .en(adj_pend),
    .limit(TIMEOUT),
    .expire(expire)
  );
  // next state: grants first, a preempting time load returns to the pending adjustment
  always_comb
    nxt = g_time ? S_LD_TIME :
          g_per ? S_LD_PERIOD :
          g_adj ? S_ADJ_ISSUE :
          state == S_LD_TIME ? ((adj_pend && !fin) ? S_ADJ_WAIT : S_IDLE) :
          state == S_ADJ_ISSUE ? (adj_zero ? S_IDLE : S_ADJ_WAIT) :
          state == S_ADJ_WAIT ? (fin ? S_IDLE : S_ADJ_WAIT) : S_IDLE;
  // state, arming delay after reset, adjustment tracking and completion pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      armed <= 1'b0;
      adj_pend <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      armed <= 1'b1;
      adj_pend <= aj_ack ? !adj_zero : (adj_pend && !fin);
      done_q <= fin;
      err_q <= fin && !adj_ld_done;
    end
  // payload registers capture at the grant edge and hold between strobes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      time_reg_ns_in <= '0;
      time_reg_sec_in <= '0;
      period_in <= '0;
      adj_ld_data <= '0;
      period_adj <= '0;
    end else begin
      if (g_time) begin
        time_reg_ns_in <= tl_ns;
        time_reg_sec_in <= tl_sec;
      end
      if (g_per) period_in <= pl_period;
      if (g_adj) begin
        adj_ld_data <= aj_cycles;
        period_adj <= aj_period;
      end
    end
endmodule

// File: tb/tb_rtc_ctrl_arb.sv
// tb_rtc_ctrl_arb: table-driven and directed checks of the rtc control arbiter
module tb_rtc_ctrl_arb;
  logic clk = 1'b0, rst = 1'b1;
  logic tl_req = 0, pl_req = 0, aj_req = 0, adj_ld_done = 0;
  logic [37:0] tl_ns = '0;
  logic [47:0] tl_sec = '0;
  logic [39:0] pl_period = '0, aj_period = '0;
  logic [31:0] aj_cycles = '0;
  logic tl_ack, pl_ack, aj_ack, aj_done, aj_err, time_ld, period_ld, adj_ld, busy;
  logic [37:0] time_reg_ns_in;
  logic [47:0] time_reg_sec_in;
  logic [39:0] period_in, period_adj;
  logic [31:0] adj_ld_data;
  int errors = 0, checks = 0;
  logic [37:0] m_ns = '0;
  logic [47:0] m_sec = '0;
  logic [39:0] m_per = '0;
  bit ok;

  typedef struct {
    logic tl, pl;
    logic [37:0] ns;
    logic [47:0] sec;
    logic [39:0] per;
    logic e1t, e1p, e2p;
  } vec_t;
  vec_t v[5];

  rtc_ctrl_arb #(.TIMEOUT(32'd16), .PRIO_TIME(1)) dut (
    .rst(rst), .clk(clk),
    .tl_req(tl_req), .tl_ns(tl_ns), .tl_sec(tl_sec), .tl_ack(tl_ack),
    .pl_req(pl_req), .pl_period(pl_period), .pl_ack(pl_ack),
    .aj_req(aj_req), .aj_cycles(aj_cycles), .aj_period(aj_period), .aj_ack(aj_ack),
    .aj_done(aj_done), .aj_err(aj_err),
    .time_ld(time_ld), .time_reg_ns_in(time_reg_ns_in), .time_reg_sec_in(time_reg_sec_in),
    .period_ld(period_ld), .period_in(period_in),
    .adj_ld(adj_ld), .adj_ld_data(adj_ld_data), .period_adj(period_adj),
    .adj_ld_done(adj_ld_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk(name, {time_reg_ns_in, time_reg_sec_in, period_in, adj_ld_data, period_adj,
               time_ld, tl_ack, period_ld, pl_ack, adj_ld, aj_ack, aj_done, aj_err, busy}, '0);
  endtask

  task automatic chk_data(input string name);
    chk({name, "_ns"}, time_reg_ns_in, m_ns);
    chk({name, "_sec"}, time_reg_sec_in, m_sec);
    chk({name, "_per"}, period_in, m_per);
  endtask

  task automatic wait_adj(output bit found);
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      step();
      if (adj_ld === 1'b1) found = 1;
    end
    chk("adj_ld_seen", found, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    v[0] = '{1'b0, 1'b1, 38'h0, 48'h0, 40'h08_00000000, 1'b0, 1'b1, 1'b0};
    v[1] = '{1'b1, 1'b1, {30'd999999900, 8'h00}, 48'd10, 40'h01_23456789, 1'b1, 1'b0, 1'b1};
    v[2] = '{1'b1, 1'b0, 38'h3F_FFFFFFFF, 48'hFFFF_FFFFFFFF, 40'h0, 1'b1, 1'b0, 1'b0};
    v[3] = '{1'b0, 1'b1, 38'h0, 48'h0, 40'hFF_FFFFFFFF, 1'b0, 1'b1, 1'b0};
    v[4] = '{1'b1, 1'b1, 38'h0, 48'h0, 40'h0, 1'b1, 1'b0, 1'b1};
    #3;
    chk_zero("reset_t0");
    step();
    step();
    chk_zero("reset_held");
    rst = 0;
    step();
    chk("idle_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      tl_req = v[i].tl;
      pl_req = v[i].pl;
      tl_ns = v[i].ns;
      tl_sec = v[i].sec;
      pl_period = v[i].per;
      step();
      chk($sformatf("v%0d_time_ld", i), time_ld, v[i].e1t);
      chk($sformatf("v%0d_tl_ack", i), tl_ack, v[i].e1t);
      chk($sformatf("v%0d_period_ld", i), period_ld, v[i].e1p);
      chk($sformatf("v%0d_pl_ack", i), pl_ack, v[i].e1p);
      chk($sformatf("v%0d_busy1", i), busy, 1);
      if (v[i].e1t) begin
        m_ns = v[i].ns;
        m_sec = v[i].sec;
        tl_req = 0;
      end else begin
        m_per = v[i].per;
        pl_req = 0;
      end
      chk_data($sformatf("v%0d_g1", i));
      step();
      chk($sformatf("v%0d_busy2", i), busy, 0);
      chk($sformatf("v%0d_strobes2", i), {time_ld, period_ld, adj_ld}, 0);
      if (v[i].e2p) begin
        step();
        chk($sformatf("v%0d_period_ld2", i), period_ld, 1);
        chk($sformatf("v%0d_pl_ack2", i), pl_ack, 1);
        chk($sformatf("v%0d_time_ld2", i), time_ld, 0);
        m_per = v[i].per;
        pl_req = 0;
        step();
        chk($sformatf("v%0d_busy3", i), busy, 0);
      end
      chk_data($sformatf("v%0d_hold", i));
    end

    aj_req = 1; aj_cycles = 32'd10; aj_period = 40'h02_20800000;
    wait_adj(ok);
    aj_req = 0;
    chk("adjA_ack", aj_ack, 1);
    chk("adjA_data", adj_ld_data, 32'd10);
    chk("adjA_period", period_adj, 40'h02_20800000);
    chk("adjA_done0", aj_done, 0);
    for (int k = 1; k < 10; k++) begin
      step();
      chk("adjA_wait", {aj_done, busy, adj_ld}, 3'b010);
    end
    step();
    adj_ld_done = 1;
    step();
    adj_ld_done = 0;
    chk("adjA_done", aj_done, 1);
    chk("adjA_err", aj_err, 0);
    chk("adjA_busy", busy, 0);
    step();
    chk("adjA_done_once", aj_done, 0);

    aj_req = 1; aj_cycles = 32'd5; aj_period = 40'h01_00000000;
    wait_adj(ok);
    aj_req = 0;
    for (int k = 1; k < 16; k++) begin
      step();
      chk("tmo_early", aj_done, 0);
    end
    step();
    chk("tmo_done", aj_done, 1);
    chk("tmo_err", aj_err, 1);
    chk("tmo_busy", busy, 0);
    step();
    chk("tmo_done_once", {aj_done, aj_err}, 0);

    aj_req = 1; aj_cycles = 32'd7; aj_period = 40'h01_80000000;
    wait_adj(ok);
    aj_req = 0;
    step();
    tl_req = 1; tl_ns = 38'h12_3456789A; tl_sec = 48'd12345;
    step();
    chk("pre_time_ld", time_ld, 1);
    chk("pre_tl_ack", tl_ack, 1);
    chk("pre_busy", busy, 1);
    chk("pre_done0", aj_done, 0);
    m_ns = tl_ns; m_sec = tl_sec;
    chk_data("pre_data");
    tl_req = 0;
    pl_req = 1; pl_period = 40'h03_00000000;
    step();
    chk("pre_back_wait", {time_ld, period_ld, busy}, 3'b001);
    step();
    chk("pre_pl_held", period_ld, 0);
    adj_ld_done = 1;
    step();
    adj_ld_done = 0;
    chk("pre_done", aj_done, 1);
    chk("pre_err", aj_err, 0);
    chk("pre_pl_held2", period_ld, 0);
    step();
    chk("pre_pl_served", {period_ld, pl_ack}, 2'b11);
    m_per = pl_period;
    pl_req = 0;
    chk_data("pre_pl_data");
    step();
    chk("pre_idle", busy, 0);

    aj_req = 1; aj_cycles = 32'd3; aj_period = 40'h00_00000001;
    wait_adj(ok);
    aj_req = 0;
    step();
    tl_req = 1; adj_ld_done = 1; tl_ns = 38'h1; tl_sec = 48'h2;
    step();
    tl_req = 0; adj_ld_done = 0;
    chk("same_time_ld", time_ld, 1);
    chk("same_done", aj_done, 1);
    chk("same_err", aj_err, 0);
    m_ns = 38'h1; m_sec = 48'h2;
    chk_data("same_data");
    step();
    chk("same_idle", {busy, aj_done}, 0);

    adj_ld_done = 1;
    step();
    adj_ld_done = 0;
    chk("stray_done", {aj_done, aj_err, busy}, 0);
    step();
    chk("stray_done2", aj_done, 0);

    aj_req = 1; aj_cycles = 32'd4; aj_period = 40'h00_00000002;
    wait_adj(ok);
    aj_req = 0;
    step();
    step();
    rst = 1;
    #1;
    chk_zero("rst_mid_adj");
    aj_req = 1; aj_cycles = 32'd0; aj_period = 40'h5;
    step();
    chk_zero("rst_held_adj");
    rst = 0;
    step();
    chk("rst_no_early_grant", {busy, aj_ack, aj_done}, 0);
    step();
    chk("zero_ack", aj_ack, 1);
    chk("zero_done", aj_done, 1);
    chk("zero_err", aj_err, 1);
    chk("zero_no_adj_ld", adj_ld, 0);
    aj_req = 0;
    step();
    chk("zero_idle", {aj_ack, aj_done, aj_err, busy}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
